// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bus: next-PC/hazard inputs toward the controller and the
// PC, flush, write-enable and status outputs back to the IF stage.
interface pc_fetch_ctrl_if;
  logic [15:0] next_pc;
  logic        branch_taken;
  logic        stall;
  logic        imem_ready;
  logic        halt_dec;
  logic [15:0] pc;
  logic        flush;
  logic        ifid_we;
  logic        fetch_valid;
  logic        halted;
  logic [15:0] redirect_cnt;

  // Pipeline side: drives next-PC and hazard information, consumes fetch control.
  modport master (
    output next_pc,
    output branch_taken,
    output stall,
    output imem_ready,
    output halt_dec,
    input  pc,
    input  flush,
    input  ifid_we,
    input  fetch_valid,
    input  halted,
    input  redirect_cnt
  );

  // Controller side.
  modport slave (
    input  next_pc,
    input  branch_taken,
    input  stall,
    input  imem_ready,
    input  halt_dec,
    output pc,
    output flush,
    output ifid_we,
    output fetch_valid,
    output halted,
    output redirect_cnt
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Architectural PC register and fetch sequencing: redirects with a timed
// IF/ID flush, instruction-memory wait states, hazard stalls and sticky HLT.
module pc_fetch_ctrl #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter int unsigned FLUSH_CYCLES = 1  // legal range 1..7
) (
  input logic             clk,
  input logic             rst_n,
  pc_fetch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StMiss  = 2'd1,
    StFlush = 2'd2,
    StHalt  = 2'd3
  } state_e;

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic        halted_q, halted_d;
  logic [15:0] redirect_cnt_q, redirect_cnt_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic        ifid_we;
  logic        fetch_valid;
  logic [15:0] redirect_cnt_inc;

  assign redirect_cnt_inc = (redirect_cnt_q == 16'hFFFF) ? redirect_cnt_q
                                                         : redirect_cnt_q + 16'd1;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    flush_d        = flush_q;
    halted_d       = halted_q;
    redirect_cnt_d = redirect_cnt_q;
    flush_cnt_d    = flush_cnt_q;
    ifid_we        = 1'b0;
    fetch_valid    = 1'b0;

    unique case (state_q)
      StRun: begin
        fetch_valid = bus.imem_ready;
        ifid_we     = bus.imem_ready & ~bus.stall & ~bus.branch_taken;
        if (bus.branch_taken) begin
          pc_d           = bus.next_pc;
          flush_d        = 1'b1;
          flush_cnt_d    = FlushLoad;
          redirect_cnt_d = redirect_cnt_inc;
          state_d        = StFlush;
        end else if (bus.halt_dec) begin
          halted_d = 1'b1;
          state_d  = StHalt;
        end else if (bus.stall) begin
          pc_d = pc_q;
        end else if (!bus.imem_ready) begin
          state_d = StMiss;
        end else begin
          pc_d = bus.next_pc;
        end
      end

      StMiss: begin
        // halt_dec is not honoured here: ID holds no valid instruction.
        fetch_valid = bus.imem_ready;
        ifid_we     = bus.imem_ready & ~bus.stall & ~bus.branch_taken;
        if (bus.branch_taken) begin
          pc_d           = bus.next_pc;
          flush_d        = 1'b1;
          flush_cnt_d    = FlushLoad;
          redirect_cnt_d = redirect_cnt_inc;
          state_d        = StFlush;
        end else if (bus.imem_ready) begin
          if (!bus.stall) begin
            pc_d = bus.next_pc;
          end
          state_d = StRun;
        end
      end

      StFlush: begin
        // Branches and halts seen here come from the wrong path.
        fetch_valid = bus.imem_ready;
        ifid_we     = bus.imem_ready & ~bus.stall;
        if (bus.imem_ready && !bus.stall) begin
          pc_d = bus.next_pc;
        end
        if (flush_cnt_q == 3'd0) begin
          flush_d = 1'b0;
          state_d = StRun;
        end else begin
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end

      StHalt: begin
        flush_d  = 1'b0;
        halted_d = 1'b1;
      end

      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StRun;
      pc_q           <= RESET_PC;
      flush_q        <= 1'b0;
      halted_q       <= 1'b0;
      redirect_cnt_q <= 16'h0000;
      flush_cnt_q    <= 3'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      flush_q        <= flush_d;
      halted_q       <= halted_d;
      redirect_cnt_q <= redirect_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign bus.pc           = pc_q;
  assign bus.flush        = flush_q;
  assign bus.halted       = halted_q;
  assign bus.redirect_cnt = redirect_cnt_q;
  assign bus.ifid_we      = ifid_we;
  assign bus.fetch_valid  = fetch_valid;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: one instance with a 1-cycle flush window
// and one with a 3-cycle window, checked with immediate assertions.
module tb_pc_fetch_ctrl;

  logic clk;
  logic rst_n1;
  logic rst_n3;
  int   total;
  int   bad;

  pc_fetch_ctrl_if bus1 ();
  pc_fetch_ctrl_if bus3 ();

  pc_fetch_ctrl #(
    .RESET_PC     (16'h0000),
    .FLUSH_CYCLES (1)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n1),
    .bus   (bus1)
  );

  pc_fetch_ctrl #(
    .RESET_PC     (16'h0000),
    .FLUSH_CYCLES (3)
  ) dut3 (
    .clk   (clk),
    .rst_n (rst_n3),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n1 = 1'b0;
    rst_n3 = 1'b0;
    bus1.next_pc = 16'h0002; bus1.branch_taken = 1'b0; bus1.stall = 1'b0;
    bus1.imem_ready = 1'b1;  bus1.halt_dec = 1'b0;
    bus3.next_pc = 16'h0002; bus3.branch_taken = 1'b0; bus3.stall = 1'b0;
    bus3.imem_ready = 1'b1;  bus3.halt_dec = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_pc",      bus1.pc, 16'h0000);
    chk("rst_flush",   16'(bus1.flush), 16'h0);
    chk("rst_halted",  16'(bus1.halted), 16'h0);
    chk("rst_cnt",     bus1.redirect_cnt, 16'h0000);
    chk("rst3_pc",     bus3.pc, 16'h0000);

    // Free run
    rst_n1 = 1'b1;
    bus1.next_pc = 16'h0002;
    #1;
    chk("run_we",      16'(bus1.ifid_we), 16'h1);
    chk("run_fv",      16'(bus1.fetch_valid), 16'h1);
    tick();
    chk("run_pc1",     bus1.pc, 16'h0002);
    bus1.next_pc = 16'h0004;
    tick();
    chk("run_pc2",     bus1.pc, 16'h0004);
    chk("run_flush",   16'(bus1.flush), 16'h0);
    chk("run_cnt",     bus1.redirect_cnt, 16'h0000);

    // Taken branch, FLUSH_CYCLES=1
    bus1.next_pc = 16'h0010;
    tick();
    chk("br_pre_pc",   bus1.pc, 16'h0010);
    bus1.branch_taken = 1'b1; bus1.next_pc = 16'h0040;
    #1;
    chk("br_we",       16'(bus1.ifid_we), 16'h0);
    tick();
    chk("br_pc",       bus1.pc, 16'h0040);
    chk("br_flush",    16'(bus1.flush), 16'h1);
    chk("br_cnt",      bus1.redirect_cnt, 16'h0001);
    bus1.branch_taken = 1'b0; bus1.next_pc = 16'h0042;
    tick();
    chk("br_fl_pc",    bus1.pc, 16'h0042);
    chk("br_flush_off", 16'(bus1.flush), 16'h0);
    bus1.next_pc = 16'h0044;
    tick();
    chk("br_post_pc",  bus1.pc, 16'h0044);
    chk("br_post_fl",  16'(bus1.flush), 16'h0);

    // Memory wait
    bus1.next_pc = 16'h0020;
    tick();
    bus1.imem_ready = 1'b0; bus1.next_pc = 16'h0022;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("miss_fv",   16'(bus1.fetch_valid), 16'h0);
      chk("miss_we",   16'(bus1.ifid_we), 16'h0);
      tick();
      chk("miss_pc",   bus1.pc, 16'h0020);
    end
    bus1.imem_ready = 1'b1;
    #1;
    chk("miss_end_fv", 16'(bus1.fetch_valid), 16'h1);
    chk("miss_end_we", 16'(bus1.ifid_we), 16'h1);
    tick();
    chk("miss_end_pc", bus1.pc, 16'h0022);
    bus1.imem_ready = 1'b0;
    tick();
    bus1.branch_taken = 1'b1; bus1.next_pc = 16'h0100;
    #1;
    chk("miss_br_we",  16'(bus1.ifid_we), 16'h0);
    tick();
    chk("miss_br_pc",  bus1.pc, 16'h0100);
    chk("miss_br_fl",  16'(bus1.flush), 16'h1);
    chk("miss_br_cnt", bus1.redirect_cnt, 16'h0002);
    bus1.branch_taken = 1'b0; bus1.imem_ready = 1'b1; bus1.next_pc = 16'h0102;
    tick();
    chk("miss_br_pc2", bus1.pc, 16'h0102);

    // Stall, then stall with branch
    bus1.stall = 1'b1; bus1.next_pc = 16'h0104;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stall_we",  16'(bus1.ifid_we), 16'h0);
      tick();
      chk("stall_pc",  bus1.pc, 16'h0102);
    end
    bus1.branch_taken = 1'b1; bus1.next_pc = 16'h0080;
    tick();
    chk("stbr_pc",     bus1.pc, 16'h0080);
    chk("stbr_fl",     16'(bus1.flush), 16'h1);
    chk("stbr_cnt",    bus1.redirect_cnt, 16'h0003);
    bus1.branch_taken = 1'b0; bus1.stall = 1'b0; bus1.next_pc = 16'h0082;
    tick();
    chk("stbr_pc2",    bus1.pc, 16'h0082);

    // Halt
    bus1.next_pc = 16'h0030;
    tick();
    bus1.halt_dec = 1'b1; bus1.next_pc = 16'h0032;
    tick();
    chk("hlt_halted",  16'(bus1.halted), 16'h1);
    chk("hlt_pc",      bus1.pc, 16'h0030);
    bus1.halt_dec = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus1.branch_taken = i[0];
      bus1.imem_ready   = ~i[0];
      bus1.next_pc      = 16'(32'h0200 + i);
      #1;
      chk("hlt_we",    16'(bus1.ifid_we), 16'h0);
      chk("hlt_fv",    16'(bus1.fetch_valid), 16'h0);
      tick();
      chk("hlt_pc_frz", bus1.pc, 16'h0030);
      chk("hlt_flush", 16'(bus1.flush), 16'h0);
    end
    chk("hlt_sticky",  16'(bus1.halted), 16'h1);
    chk("hlt_cnt",     bus1.redirect_cnt, 16'h0003);
    bus1.branch_taken = 1'b0; bus1.imem_ready = 1'b1;
    rst_n1 = 1'b0;
    tick();
    chk("hlt_rst_pc",  bus1.pc, 16'h0000);
    chk("hlt_rst_h",   16'(bus1.halted), 16'h0);
    chk("hlt_rst_cnt", bus1.redirect_cnt, 16'h0000);
    rst_n1 = 1'b1;

    // PC wrap
    bus1.next_pc = 16'hFFFE;
    tick();
    chk("wrap_hi",     bus1.pc, 16'hFFFE);
    bus1.next_pc = 16'h0000;
    tick();
    chk("wrap_lo",     bus1.pc, 16'h0000);

    // FLUSH_CYCLES=3: window length and wrong-path branch
    rst_n3 = 1'b1;
    bus3.next_pc = 16'h0010;
    tick();
    bus3.branch_taken = 1'b1; bus3.next_pc = 16'h0040;
    tick();
    chk("f3_pc",       bus3.pc, 16'h0040);
    chk("f3_fl1",      16'(bus3.flush), 16'h1);
    chk("f3_cnt1",     bus3.redirect_cnt, 16'h0001);
    bus3.stall = 1'b1; bus3.next_pc = 16'h0900;
    tick();
    chk("f3_fl2",      16'(bus3.flush), 16'h1);
    chk("f3_wp_pc",    bus3.pc, 16'h0040);
    chk("f3_wp_cnt",   bus3.redirect_cnt, 16'h0001);
    bus3.branch_taken = 1'b0; bus3.stall = 1'b0; bus3.next_pc = 16'h0042;
    tick();
    chk("f3_fl3",      16'(bus3.flush), 16'h1);
    chk("f3_pc3",      bus3.pc, 16'h0042);
    bus3.next_pc = 16'h0044;
    tick();
    chk("f3_fl_off",   16'(bus3.flush), 16'h0);
    chk("f3_pc4",      bus3.pc, 16'h0044);

    // Reset in the middle of a flush window
    bus3.branch_taken = 1'b1; bus3.next_pc = 16'h0060;
    tick();
    chk("f3r_fl",      16'(bus3.flush), 16'h1);
    chk("f3r_cnt",     bus3.redirect_cnt, 16'h0002);
    bus3.branch_taken = 1'b0; bus3.next_pc = 16'h0062;
    rst_n3 = 1'b0;
    tick();
    chk("f3r_fl0",     16'(bus3.flush), 16'h0);
    chk("f3r_pc",      bus3.pc, 16'h0000);
    chk("f3r_cnt0",    bus3.redirect_cnt, 16'h0000);
    rst_n3 = 1'b1; bus3.next_pc = 16'h0002;
    #1;
    chk("f3r_we",      16'(bus3.ifid_we), 16'h1);
    tick();
    chk("f3r_run_pc",  bus3.pc, 16'h0002);
    chk("f3r_run_fl",  16'(bus3.flush), 16'h0);

    // Redirect counter saturation (dut1 count is 0 after the halt reset)
    bus1.next_pc = 16'h1000;
    for (int i = 0; i < 65534; i++) begin
      bus1.branch_taken = 1'b1;
      tick();
      bus1.branch_taken = 1'b0;
      tick();
    end
    chk("sat_fffe",    bus1.redirect_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      bus1.branch_taken = 1'b1;
      tick();
      bus1.branch_taken = 1'b0;
      tick();
      chk("sat_ffff",  bus1.redirect_cnt, 16'hFFFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
